// File: rtl/pipe_pkg.sv
// Shared types for the ID-stage hazard/forwarding controller: forwarding
// select codes, sequencer states and the scoreboard entry layout.
package pipe_pkg;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_EXA  = 2'b01;
  localparam logic [1:0] FWD_MEMA = 2'b10;
  localparam logic [1:0] FWD_MEML = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  typedef struct packed {
    logic       wreg;
    logic       m2reg;
    logic [4:0] rn;
  } sb_ent_t;

  localparam sb_ent_t SB_NOP = '0;

endpackage

// File: rtl/pipe_hazard_ctl_if.sv
// Decoder/memory-side bundle for pipe_hazard_ctl: ID-stage operand info in,
// forwarding selects and pipeline enables out.
interface pipe_hazard_ctl_if #(parameter int CNT_W = 16);
  logic [4:0]       id_rs, id_rt, id_rn;
  logic             id_use_rs, id_use_rt, id_wreg, id_m2reg, id_bubble;
  logic             mem_req, dmem_ready;
  logic [1:0]       fwda, fwdb;
  logic             wpcir, id_kill, if_flush, pipe_en, bus_err;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_rs, id_rt, id_rn, id_use_rs, id_use_rt, id_wreg, id_m2reg,
           id_bubble, mem_req, dmem_ready,
    input  fwda, fwdb, wpcir, id_kill, if_flush, pipe_en, bus_err, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_rn, id_use_rs, id_use_rt, id_wreg, id_m2reg,
           id_bubble, mem_req, dmem_ready,
    output fwda, fwdb, wpcir, id_kill, if_flush, pipe_en, bus_err, stall_cnt
  );
endinterface

// File: rtl/pipe_fwd_sel.sv
// One ID operand's compare against the EX/MEM scoreboard: forwarding select
// plus a flag for a pending load in EX targeting this operand.
module pipe_fwd_sel
  import pipe_pkg::*;
(
  input  logic [4:0] r,
  input  sb_ent_t    ex,
  input  sb_ent_t    mem,
  output logic [1:0] sel,
  output logic       ld_hit
);
  logic ex_hit, mem_hit;

  // $0 is hardwired, so a write to it must never be seen as a producer
  assign ex_hit  = ex.wreg  && (ex.rn  != 5'd0) && (ex.rn  == r);
  assign mem_hit = mem.wreg && (mem.rn != 5'd0) && (mem.rn == r);
  assign ld_hit  = ex_hit && ex.m2reg;

  always_comb begin
    sel = FWD_RF;
    if (ex_hit && !ex.m2reg) sel = FWD_EXA;
    else if (mem_hit)        sel = mem.m2reg ? FWD_MEML : FWD_MEMA;
  end
endmodule

// File: rtl/pipe_hazard_ctl.sv
// Pipeline sequencer for the 5-stage MIPS core: EX/MEM destination scoreboard,
// ID forwarding, load-use stall, branch flush and a memory-wait freeze with watchdog.
module pipe_hazard_ctl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input logic               clock,
  input logic               resetn,
  pipe_hazard_ctl_if.slave  bus
);
  localparam int NUM_OPS = 2;
  localparam int WCNT_W  = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MEM_TIMEOUT);

  sb_ent_t            ex_q, mem_q, id_ent;
  state_t             state;
  logic [WCNT_W-1:0]  wcnt;
  logic               bus_err_q;
  logic [CNT_W-1:0]   stall_cnt_q;

  logic [NUM_OPS-1:0][4:0] op_r;
  logic [NUM_OPS-1:0][1:0] op_sel;
  logic [NUM_OPS-1:0]      op_use, ld_hit;
  logic mem_stall, hold, lu, flush, pipe_en, wpcir;

  assign id_ent = '{wreg: bus.id_wreg, m2reg: bus.id_m2reg, rn: bus.id_rn};
  assign op_r   = {bus.id_rt, bus.id_rs};
  assign op_use = {bus.id_use_rt, bus.id_use_rs};

  generate
    for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
      pipe_fwd_sel u_sel (
        .r      (op_r[i]),
        .ex     (ex_q),
        .mem    (mem_q),
        .sel    (op_sel[i]),
        .ld_hit (ld_hit[i])
      );
    end
  endgenerate

  // Gated by resetn so the control outputs sit at their idle values while in reset
  assign mem_stall = bus.mem_req && !bus.dmem_ready;
  assign hold      = resetn && (mem_stall || state == ST_ERR);
  assign lu        = resetn && !hold && |(op_use & ld_hit);
  assign flush     = resetn && !hold && !lu && bus.id_bubble;
  assign pipe_en   = !hold;
  assign wpcir     = !hold && !lu;

  assign bus.fwda      = op_sel[0];
  assign bus.fwdb      = op_sel[1];
  assign bus.wpcir     = wpcir;
  assign bus.id_kill   = lu;
  assign bus.if_flush  = flush;
  assign bus.pipe_en   = pipe_en;
  assign bus.bus_err   = bus_err_q;
  assign bus.stall_cnt = stall_cnt_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ex_q        <= SB_NOP;
      mem_q       <= SB_NOP;
      state       <= ST_RUN;
      wcnt        <= '0;
      bus_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      if (pipe_en) begin
        mem_q <= ex_q;
        ex_q  <= lu ? SB_NOP : id_ent;
      end
      if (!wpcir && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 1'b1;
      case (state)
        ST_RUN:
          if (mem_stall) begin
            state <= ST_WAIT;
            wcnt  <= WCNT_W'(1);
          end
        // a ready in the timeout cycle takes the RUN branch first, so no error
        ST_WAIT:
          if (!mem_stall) begin
            state <= ST_RUN;
            wcnt  <= '0;
          end else if (wcnt == WCNT_MAX) begin
            state     <= ST_ERR;
            bus_err_q <= 1'b1;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        ST_ERR:  state <= ST_ERR;
        default: state <= ST_RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Bench for pipe_hazard_ctl: directed and random ID/memory traffic, expected
// outputs from an instruction-level pipeline model pushed to a scoreboard queue.
module tb_pipe_hazard_ctl;
  localparam int TO = 4;
  localparam int CW = 4;
  localparam int SMAX = (1 << CW) - 1;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  pipe_hazard_ctl_if #(.CNT_W(CW)) bus ();

  pipe_hazard_ctl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  typedef struct {
    logic [1:0]    fa, fb;
    logic          wp, kill, flush, pen, berr;
    logic [CW-1:0] scnt;
  } exp_t;

  typedef struct {
    bit w;
    bit m;
    int rn;
  } ins_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // model state: stg[0] is the instruction in EX, stg[1] the one in MEM
  ins_t stg[2];
  int   consec;
  bit   err;
  int   scnt;

  function automatic int fwd_of(int r);
    if (stg[0].w && stg[0].rn != 0 && stg[0].rn == r && !stg[0].m) return 1;
    if (stg[1].w && stg[1].rn != 0 && stg[1].rn == r) return stg[1].m ? 3 : 2;
    return 0;
  endfunction

  task automatic model_clear();
    stg[0] = '{0, 0, 0};
    stg[1] = '{0, 0, 0};
    consec = 0;
    err    = 0;
    scnt   = 0;
  endtask

  task automatic step(input int rs, input int rt, input bit urs, input bit urt,
                      input bit wr, input bit m2, input int rn, input bit bub,
                      input bit mreq, input bit rdy);
    exp_t e;
    bit waiting, hold, lu;
    bus.id_rs = 5'(rs);  bus.id_rt = 5'(rt);  bus.id_rn = 5'(rn);
    bus.id_use_rs = urs; bus.id_use_rt = urt;
    bus.id_wreg = wr;    bus.id_m2reg = m2;   bus.id_bubble = bub;
    bus.mem_req = mreq;  bus.dmem_ready = rdy;
    waiting = mreq && !rdy;
    hold    = err || waiting;
    lu      = !hold && stg[0].w && stg[0].m && stg[0].rn != 0 &&
              ((urs && stg[0].rn == rs) || (urt && stg[0].rn == rt));
    e.fa    = 2'(fwd_of(rs));
    e.fb    = 2'(fwd_of(rt));
    e.pen   = !hold;
    e.wp    = !hold && !lu;
    e.kill  = lu;
    e.flush = !hold && !lu && bub;
    e.berr  = err;
    e.scnt  = CW'(scnt);
    exp_q.push_back(e);
    if (!hold) begin
      stg[1] = stg[0];
      stg[0] = lu ? '{0, 0, 0} : '{wr, m2, rn};
    end
    if (!e.wp && scnt < SMAX) scnt++;
    if (!err) begin
      if (waiting) begin
        if (consec == TO) err = 1;
        else consec++;
      end else consec = 0;
    end
    @(posedge clock); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic do_reset();
    exp_t e;
    resetn = 1'b0;
    bus.id_rs = 5'($urandom_range(0, 3)); bus.id_rt = 5'($urandom_range(0, 3));
    bus.id_rn = 5'($urandom_range(0, 3));
    bus.id_use_rs = 1'b1; bus.id_use_rt = 1'b1; bus.id_wreg = 1'b1; bus.id_m2reg = 1'b1;
    bus.id_bubble = 1'b1; bus.mem_req = 1'b1; bus.dmem_ready = 1'b0;
    e = '{fa: 2'd0, fb: 2'd0, wp: 1'b1, kill: 1'b0, flush: 1'b0, pen: 1'b1,
          berr: 1'b0, scnt: '0};
    exp_q.push_back(e);
    model_clear();
    @(posedge clock); #1;
    resetn = 1'b1;
  endtask

  exp_t        me;
  logic [12:0] act, want;

  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      if (exp_q.size() > 0) begin
        me   = exp_q.pop_front();
        act  = {bus.fwda, bus.fwdb, bus.wpcir, bus.id_kill, bus.if_flush,
                bus.pipe_en, bus.bus_err, bus.stall_cnt};
        want = {me.fa, me.fb, me.wp, me.kill, me.flush, me.pen, me.berr, me.scnt};
        total++;
        if (act !== want) begin
          bad++;
          $display("FAIL outputs cyc=%0d got fa=%0d fb=%0d wp=%0b kill=%0b flush=%0b pen=%0b err=%0b scnt=%0d want fa=%0d fb=%0d wp=%0b kill=%0b flush=%0b pen=%0b err=%0b scnt=%0d",
                   cyc, act[12:11], act[10:9], act[8], act[7], act[6], act[5], act[4], act[3:0],
                   want[12:11], want[10:9], want[8], want[7], want[6], want[5], want[4], want[3:0]);
        end
      end
    end
  end

  initial begin
    int pct;
    @(posedge clock); #1;
    do_reset();
    // forwarding from EX, from MEM, and EX priority when both match
    step(0, 0, 0, 0, 1, 0, 3, 0, 0, 1);
    step(3, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0, 3, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(3, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0, 3, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0, 3, 0, 0, 1);
    step(3, 3, 1, 1, 0, 0, 0, 0, 0, 1);
    // load-use: stall one cycle, then the load forwards from MEM
    step(0, 0, 0, 0, 1, 1, 5, 0, 0, 1);
    step(5, 1, 1, 1, 1, 0, 7, 0, 0, 1);
    step(5, 1, 1, 1, 1, 0, 7, 0, 0, 1);
    // writes to $0 never forward or stall
    step(0, 0, 0, 0, 1, 1, 0, 0, 0, 1);
    step(0, 0, 1, 1, 0, 0, 0, 0, 0, 1);
    // branch flush, and a branch behind a load
    step(1, 2, 1, 1, 0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 1, 1, 6, 0, 0, 1);
    step(1, 6, 1, 1, 0, 0, 0, 1, 0, 1);
    step(1, 6, 1, 1, 0, 0, 0, 1, 0, 1);
    // 3-cycle memory wait, then ready
    step(0, 0, 0, 0, 1, 0, 2, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(2, 0, 1, 0, 1, 0, 4, 0, 1, 0);
    step(2, 0, 1, 0, 1, 0, 4, 0, 1, 1);
    idle(2);
    // ready arriving exactly on the timeout compare cycle
    for (int i = 0; i < TO; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(2);
    // watchdog timeout, sticky error, reset clears it
    for (int i = 0; i < TO + 4; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    step(1, 1, 1, 1, 1, 0, 1, 1, 0, 1);
    idle(2);
    do_reset();
    idle(2);
    // random phases with varying memory-wait pressure and occasional resets
    for (int ph = 0; ph < 8; ph++) begin
      pct = (ph % 3 == 0) ? 60 : ((ph % 3 == 1) ? 15 : 3);
      do_reset();
      for (int n = 0; n < 200; n++) begin
        if ($urandom_range(0, 99) == 0) do_reset();
        step($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), 1'($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) >= pct));
      end
    end
    repeat (3) @(negedge clock);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain left=%0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
